// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencer for the 5-stage MIPS core.
// Resolves the hazards the forwarding unit cannot:
//   - load-use stalls;
//   - ID-stage branch operand stalls of 1 or 2 cycles;
//   - taken branch/jump squash of IF/ID;
//   - whole-pipeline freeze while the data memory is busy.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   IDRs, IDRt          ID-stage source registers
//   IDUsesRt            ID instruction reads rt
//   IDBranch            ID holds a conditional branch
//   branchTaken         ID comparator result
//   IDJump              ID holds a jump
//   EXEMemRead          EXE is a load
//   EXERegWrite         EXE writes a register
//   EXEDest             EXE destination register
//   MEMMemRead          MEM is a load
//   MEMDest             MEM destination register
//   memReq, memReady    data access active / completes this cycle
//   PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite   register write enables
//   IFIDFlush           squash IF/ID
//   IDEXBubble          insert NOP into ID/EX
//   MEMWBBubble         insert NOP into MEM/WB
//   hazardState         00 RUN, 01 STALL, 10 MEMWAIT
//   stallCycles, flushCount   statistics counters (zero unless HAZARD_STATS_EN)
module hazard_controller #(
  parameter int unsigned STALL_CNT_W = 2,
  parameter int unsigned STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        IDRs,
  input  logic [4:0]        IDRt,
  input  logic              IDUsesRt,
  input  logic              IDBranch,
  input  logic              branchTaken,
  input  logic              IDJump,
  input  logic              EXEMemRead,
  input  logic              EXERegWrite,
  input  logic [4:0]        EXEDest,
  input  logic              MEMMemRead,
  input  logic [4:0]        MEMDest,
  input  logic              memReq,
  input  logic              memReady,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IDEXWrite,
  output logic              EXMEMWrite,
  output logic              IFIDFlush,
  output logic              IDEXBubble,
  output logic              MEMWBBubble,
  output logic [1:0]        hazardState,
  output logic [STAT_W-1:0] stallCycles,
  output logic [STAT_W-1:0] flushCount
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StStall   = 2'b01,
    StMemWait = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  state_e                 saved_q, saved_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic exe_hit, mem_hit;
  logic lu, br1, br2, mw;
  logic do_stall, do_freeze, do_flush;

  // $0 is hard-wired zero, so it never creates a dependency.
  assign exe_hit = (EXEDest != 5'd0) &&
                   ((EXEDest == IDRs) || (IDUsesRt && (EXEDest == IDRt)));
  assign mem_hit = (MEMDest != 5'd0) &&
                   ((MEMDest == IDRs) || (IDUsesRt && (MEMDest == IDRt)));

  assign lu  = EXEMemRead && exe_hit;
  assign br2 = IDBranch && EXEMemRead && exe_hit;
  assign br1 = IDBranch && ((EXERegWrite && !EXEMemRead && exe_hit) ||
                            (MEMMemRead && mem_hit));
  assign mw  = memReq && !memReady;

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    do_stall  = 1'b0;
    do_freeze = 1'b0;
    do_flush  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mw) begin
          do_freeze = 1'b1;
          saved_d   = StRun;
          state_d   = StMemWait;
        end else if (br2) begin
          do_stall = 1'b1;
          cnt_d    = STALL_CNT_W'(1);
          state_d  = StStall;
        end else if (br1 || lu) begin
          do_stall = 1'b1;
        end else if ((IDBranch && branchTaken) || IDJump) begin
          do_flush = 1'b1;
        end
      end
      StStall: begin
        // Hazard detection is suppressed; only the remaining count matters.
        if (mw) begin
          do_freeze = 1'b1;
          saved_d   = StStall;
          state_d   = StMemWait;
        end else begin
          do_stall = 1'b1;
          cnt_d    = cnt_q - STALL_CNT_W'(1);
          if (cnt_q == STALL_CNT_W'(1)) state_d = StRun;
        end
      end
      StMemWait: begin
        if (!memReady) begin
          do_freeze = 1'b1;
        end else begin
          // Release; an interrupted branch stall keeps its stall set.
          do_stall = (saved_q == StStall);
          state_d  = saved_q;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    if (rst) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      IFIDFlush   = 1'b1;
      IDEXBubble  = 1'b1;
      MEMWBBubble = 1'b1;
      hazardState = StRun;
    end else begin
      PCWrite     = !(do_stall || do_freeze);
      IFIDWrite   = !(do_stall || do_freeze);
      IDEXWrite   = !do_freeze;
      EXMEMWrite  = !do_freeze;
      IFIDFlush   = do_flush;
      IDEXBubble  = do_stall;
      MEMWBBubble = do_freeze;
      hazardState = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      saved_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (do_stall || do_freeze) stall_cycles_q <= stall_cycles_q + STAT_W'(1);
      if (do_flush)              flush_count_q  <= flush_count_q + STAT_W'(1);
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushCount  = flush_count_q;
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif

endmodule
